pack_recv: RTL
==============

PACK_RECV -- requirements
Module: pack_recv

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: i_Clock cycles per UART bit (min 4).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 1740: inter-byte timeout in clocks (used only with PACK_RECV_TIMEOUT_EN).
REQ-003 SHALL have port i_Clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_en  in  1  packet capture enable.
REQ-006 SHALL have port i_Rx_Serial  in  1  UART line, 8N1, idle high, asynchronous to i_Clock.
REQ-007 SHALL have port o_data_one  out  8  first byte of last complete packet.
REQ-008 SHALL have port o_data_two  out  8  second byte of last complete packet.
REQ-009 SHALL have port o_Pkt_DV  out  1  one-cycle pulse: new packet on o_data_one/o_data_two.
REQ-010 SHALL have port o_Rx_Active  out  1  high from start-bit detect to end of stop bit.
REQ-011 SHALL have port o_Frame_Err  out  1  one-cycle pulse: stop bit sampled low.

Function
REQ-012 SHALL pass i_Rx_Serial through a two-flop synchronizer (both flops reset to 1) before any use.
REQ-013 Bit receiver SHALL be an FSM with states IDLE, START, DATA, STOP, CLEANUP.
REQ-014 IDLE -> START on synchronized line = 0; bit-cycle counter cleared, o_Rx_Active set.
REQ-015 START SHALL re-sample at count CLKS_PER_BIT/2 (integer division); line 0 -> DATA, line 1 -> IDLE (glitch rejected, no byte, no error).
REQ-016 DATA SHALL sample 8 bits LSB first, each exactly CLKS_PER_BIT clocks after the previous sample; 3-bit index wraps 7 -> STOP.
REQ-017 STOP SHALL sample CLKS_PER_BIT clocks after bit 7; 1 -> byte valid, 0 -> o_Frame_Err pulse, byte discarded.
REQ-018 CLEANUP SHALL last one cycle, clear o_Rx_Active, return to IDLE.
REQ-019 Packet assembler SHALL hold a 1-bit byte index (0 = expecting first, 1 = expecting second) and an 8-bit hold register.
REQ-020 Valid byte with i_en = 1 and index 0: byte -> hold register, index -> 1; outputs unchanged.
REQ-021 Valid byte with i_en = 1 and index 1: o_data_one <= hold, o_data_two <= byte, o_Pkt_DV = 1 for one cycle, index -> 0, all in the cycle after the stop sample.
REQ-022 Valid byte with i_en = 0 SHALL be discarded and index forced to 0.
REQ-023 Frame error SHALL force index to 0 (partial packet dropped).
REQ-024 o_data_one/o_data_two SHALL hold their values until the next o_Pkt_DV.
REQ-025 Bit receiver SHALL run regardless of i_en, keeping byte framing.
REQ-026 Back-to-back bytes (next start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-027 i_Rst_n low SHALL immediately force: FSM IDLE, counters 0, index 0, hold 8'h00, o_data_one 8'h00, o_data_two 8'h00, o_Pkt_DV 0, o_Rx_Active 0, o_Frame_Err 0, synchronizer 1.
REQ-028 Reset mid-byte or mid-packet SHALL discard all partial data; no pulse on release.
REQ-029 After release, a line already low SHALL be treated as a start bit only after passing through the synchronizer (REQ-012).

Configuration
REQ-030 Macro PACK_RECV_TIMEOUT_EN defined: timeout counter cleared on each start-bit detect and while index = 0, incrementing while index = 1 and FSM IDLE; at TIMEOUT_CLKS-1 index -> 0, hold byte dropped.
REQ-031 Same-cycle start-bit detect and timeout expiry: start-bit detect wins (counter cleared, index kept).
REQ-032 Macro not defined: no timeout logic; index 1 held indefinitely.

Verification (CLKS_PER_BIT = 4, TIMEOUT_CLKS = 100)
REQ-033 Send 8'hA5 then 8'h3C, i_en = 1 -> single o_Pkt_DV pulse, o_data_one = 8'hA5, o_data_two = 8'h3C.
REQ-034 Send 8'h11, then 8'h22 with stop bit 0, then 8'h33, 8'h44 -> o_Frame_Err pulse once; one packet 8'h33/8'h44.
REQ-035 2-clock low glitch on idle line -> no o_Rx_Active beyond START, no byte, no error.
REQ-036 i_en = 0 during 8'h55, i_en = 1 for 8'h66, 8'h77 -> packet 8'h66/8'h77 only.
REQ-037 With PACK_RECV_TIMEOUT_EN: 8'h01, 150-clock gap, 8'h02, 8'h03 -> packet 8'h02/8'h03; without macro -> packet 8'h01/8'h02.
REQ-038 Assert i_Rst_n low during second byte of a packet, then send 8'hF0, 8'h0F -> outputs 8'h00 after reset, then packet 8'hF0/8'h0F.

Source files
------------

// File: rtl/pack_recv.sv
// ---------------------------------------------------------------------------
// pack_recv -- UART (8N1) receiver that pairs consecutive bytes into packets.
//
// A bit-level receiver recovers bytes from the serial line; a small assembler
// collects two valid bytes and presents them together with a one-cycle strobe.
//
// Parameters
//   CLKS_PER_BIT  i_Clock cycles per UART bit (minimum 4)
//   TIMEOUT_CLKS  inter-byte timeout in clocks (only with PACK_RECV_TIMEOUT_EN)
//
// Build option
//   PACK_RECV_TIMEOUT_EN  when defined, a half-received packet is dropped if
//                         the line stays idle for TIMEOUT_CLKS clocks between
//                         the first and second byte.
//
// Ports
//   i_Clock      in   sole clock, rising edge
//   i_Rst_n      in   asynchronous active-low reset
//   i_en         in   packet capture enable
//   i_Rx_Serial  in   UART line, idle high, asynchronous to i_Clock
//   o_data_one   out  first byte of the last complete packet
//   o_data_two   out  second byte of the last complete packet
//   o_Pkt_DV     out  one-cycle pulse: new packet on o_data_one/o_data_two
//   o_Rx_Active  out  high from start-bit detect to end of stop bit
//   o_Frame_Err  out  one-cycle pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module pack_recv #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_CLKS = 1740
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_en,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_data_one,
    output logic [7:0] o_data_two,
    output logic       o_Pkt_DV,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // The start-bit re-sample happens on the edge where the count reaches
    // CLKS_PER_BIT/2, i.e. while the register still holds one less.  With the
    // two-flop synchronizer plus the IDLE detect cycle this lands every sample
    // close to mid-bit, which keeps back-to-back bytes aligned.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 2) begin : g_param_check
            $error("pack_recv: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; both stages reset to the idle line level so a
    // line that is low at reset release is seen only after two clocks.
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_Rx_Serial;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Bit receiver
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;

    logic start_det;
    logic stop_tick;
    logic byte_done;
    logic frame_bad;

    assign start_det = (state_reg == IDLE) && !rx_sync_reg;
    assign stop_tick = (state_reg == STOP) && (clk_cnt_reg == FULL_M1);
    assign byte_done = stop_tick && rx_sync_reg;
    assign frame_bad = stop_tick && !rx_sync_reg;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_Frame_Err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    clk_cnt_reg <= '0;
                    if (!rx_sync_reg) begin
                        state_reg   <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt_reg == HALF_M1) begin
                        clk_cnt_reg <= '0;
                        if (!rx_sync_reg) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= 3'd0;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            state_reg   <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (clk_cnt_reg == FULL_M1) begin
                        clk_cnt_reg <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (clk_cnt_reg == FULL_M1) begin
                        clk_cnt_reg <= '0;
                        o_Frame_Err <= !rx_sync_reg;
                        state_reg   <= CLEANUP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end

                CLEANUP: begin
                    o_Rx_Active <= 1'b0;
                    state_reg   <= IDLE;
                end

                default: begin
                    state_reg   <= IDLE;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional inter-byte timeout
    // ------------------------------------------------------------------
    logic byte_idx_reg;
    logic tmo_expire;

`ifdef PACK_RECV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // A start bit arriving on the expiry cycle takes precedence: the packet
    // in progress is kept because its second byte is now on the way.
    assign tmo_expire = byte_idx_reg && (state_reg == IDLE) && !start_det &&
                        (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (start_det || !byte_idx_reg || tmo_expire) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end
`else
    assign tmo_expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Packet assembler
    // ------------------------------------------------------------------
    logic [7:0] hold_reg;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            byte_idx_reg <= 1'b0;
            hold_reg     <= 8'h00;
            o_data_one   <= 8'h00;
            o_data_two   <= 8'h00;
            o_Pkt_DV     <= 1'b0;
        end else begin
            o_Pkt_DV <= 1'b0;
            if (byte_done) begin
                if (!i_en) begin
                    byte_idx_reg <= 1'b0;
                end else if (!byte_idx_reg) begin
                    hold_reg     <= shift_reg;
                    byte_idx_reg <= 1'b1;
                end else begin
                    o_data_one   <= hold_reg;
                    o_data_two   <= shift_reg;
                    o_Pkt_DV     <= 1'b1;
                    byte_idx_reg <= 1'b0;
                end
            end else if (frame_bad || tmo_expire) begin
                // Drop any half-built packet.
                byte_idx_reg <= 1'b0;
            end
        end
    end

endmodule
